vm_transaction_controller: RTL and testbench

//  Sequences one vending transaction: keypad row/col entry, item lookup, coin credit, dispense handshake, change/refund.

---
 rtl/vm_transaction_controller.sv | 214 +++++++++++++++++++++
 tb/tb_vm_transaction_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_transaction_controller.sv
// Vending transaction sequencer: keypad row/col entry, item lookup handshake,
// coin credit with saturation, dispense handshake, change/refund and inactivity timeout.
module vm_transaction_controller #(
  parameter int PRICE_W        = 12,
  parameter int COIN_W         = 8,
  parameter int MAX_ROW        = 6,
  parameter int MAX_COL        = 6,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_valid,
  input  logic [3:0]         key_digit,
  input  logic               key_cancel,
  input  logic               coin_valid,
  input  logic [COIN_W-1:0]  coin_value,
  output logic [3:0]         sel_row,
  output logic [3:0]         sel_col,
  output logic               sel_enter,
  input  logic               sel_valid,
  input  logic [3:0]         sel_dispense_row,
  input  logic [3:0]         sel_dispense_col,
  input  logic [PRICE_W-1:0] sel_price,
  output logic               dispense_req,
  output logic [3:0]         dispense_row,
  output logic [3:0]         dispense_col,
  input  logic               dispense_ack,
  output logic               change_valid,
  output logic [PRICE_W-1:0] change_amount,
  output logic               coin_reject,
  output logic               key_error,
  output logic               sold_out,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_COL, S_LOOKUP, S_WAIT_SEL, S_PAY, S_DISPENSE, S_CHANGE
  } state_e;

  localparam logic [3:0]         MAX_ROW_L  = 4'(MAX_ROW);
  localparam logic [3:0]         MAX_COL_L  = 4'(MAX_COL);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [PRICE_W-1:0] sat_add(input logic [PRICE_W-1:0] a,
                                                 input logic [COIN_W-1:0]  b);
    logic [PRICE_W:0] sum;
    sum = {1'b0, a} + (PRICE_W+1)'(b);
    sat_add = sum[PRICE_W] ? '1 : sum[PRICE_W-1:0];
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           row_q, row_d, col_q, col_d;
  logic [PRICE_W-1:0]   price_q, price_d, credit_q, credit_d, amount_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 timeout, row_ok, col_ok, sel_hold;

  logic [3:0]           sel_row_q, sel_row_d, sel_col_q, sel_col_d;
  logic [3:0]           disp_row_q, disp_row_d, disp_col_q, disp_col_d;
  logic [PRICE_W-1:0]   change_amount_q, change_amount_d;
  logic                 sel_enter_q, sel_enter_d, disp_req_q, disp_req_d;
  logic                 change_valid_q, change_valid_d, coin_reject_q, coin_reject_d;
  logic                 key_error_q, key_error_d, sold_out_q, sold_out_d, busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    price_d     = price_q;
    credit_d    = credit_q;
    amount_d    = '0;
    key_error_d = 1'b0;
    sold_out_d  = 1'b0;
    timeout     = (timer_q == TIMER_LAST);
    row_ok      = (key_digit != 4'd0) && (key_digit <= MAX_ROW_L);
    col_ok      = (key_digit != 4'd0) && (key_digit <= MAX_COL_L);

    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          if (row_ok) begin
            row_d   = key_digit;
            state_d = S_GET_COL;
          end else begin
            key_error_d = 1'b1;
          end
        end
      end
      S_GET_COL: begin
        if (key_cancel) begin
          state_d = S_IDLE;
        end else if (key_valid) begin
          if (col_ok) begin
            col_d   = key_digit;
            state_d = S_LOOKUP;
          end else begin
            key_error_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: state_d = S_WAIT_SEL;
      S_WAIT_SEL: begin
        if (sel_valid && (sel_dispense_row == row_q) && (sel_dispense_col == col_q)) begin
          price_d  = sel_price;
          credit_d = '0;
          state_d  = S_PAY;
        end else begin
          sold_out_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_PAY: begin
        if (coin_valid) credit_d = sat_add(credit_q, coin_value);
        // The dispense decision uses registered credit; a same-cycle coin still lands in credit_d.
        if (credit_q >= price_q) begin
          state_d = S_DISPENSE;
        end else if (key_cancel || timeout) begin
          amount_d = credit_d;
          state_d  = S_CHANGE;
        end
      end
      S_DISPENSE: begin
        if (dispense_ack) begin
          amount_d = credit_q - price_q;
          state_d  = S_CHANGE;
        end
      end
      S_CHANGE: begin
        credit_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (key_valid || coin_valid ||
        ((state_d != state_q) && ((state_d == S_GET_COL) || (state_d == S_PAY))))
      timer_d = '0;
    else if (!timeout)
      timer_d = timer_q + 1'b1;
    else
      timer_d = timer_q;

    sel_hold        = (state_d == S_LOOKUP) || (state_d == S_WAIT_SEL);
    sel_enter_d     = (state_d == S_LOOKUP);
    sel_row_d       = sel_hold ? row_d : 4'd0;
    sel_col_d       = sel_hold ? col_d : 4'd0;
    disp_req_d      = (state_d == S_DISPENSE);
    disp_row_d      = disp_req_d ? row_d : 4'd0;
    disp_col_d      = disp_req_d ? col_d : 4'd0;
    change_valid_d  = (state_d == S_CHANGE) && (amount_d != '0);
    change_amount_d = change_valid_d ? amount_d : '0;
    coin_reject_d   = coin_valid && (state_q != S_PAY);
    busy_d          = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      row_q           <= '0;
      col_q           <= '0;
      price_q         <= '0;
      credit_q        <= '0;
      timer_q         <= '0;
      sel_row_q       <= '0;
      sel_col_q       <= '0;
      sel_enter_q     <= 1'b0;
      disp_req_q      <= 1'b0;
      disp_row_q      <= '0;
      disp_col_q      <= '0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      coin_reject_q   <= 1'b0;
      key_error_q     <= 1'b0;
      sold_out_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      col_q           <= col_d;
      price_q         <= price_d;
      credit_q        <= credit_d;
      timer_q         <= timer_d;
      sel_row_q       <= sel_row_d;
      sel_col_q       <= sel_col_d;
      sel_enter_q     <= sel_enter_d;
      disp_req_q      <= disp_req_d;
      disp_row_q      <= disp_row_d;
      disp_col_q      <= disp_col_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      coin_reject_q   <= coin_reject_d;
      key_error_q     <= key_error_d;
      sold_out_q      <= sold_out_d;
      busy_q          <= busy_d;
    end
  end

  assign sel_row       = sel_row_q;
  assign sel_col       = sel_col_q;
  assign sel_enter     = sel_enter_q;
  assign dispense_req  = disp_req_q;
  assign dispense_row  = disp_row_q;
  assign dispense_col  = disp_col_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign coin_reject   = coin_reject_q;
  assign key_error     = key_error_q;
  assign sold_out      = sold_out_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vm_transaction_controller.sv
// Scoreboard bench for vm_transaction_controller: transaction-level stimulus pushes
// expected events; a negedge monitor pops and compares them as the DUT emits them.
module tb_vm_transaction_controller;
  localparam int PW = 12, CW = 8, MR = 6, MC = 6, TO = 8, TW = 16;
  localparam int CMAX = (1 << PW) - 1;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          key_valid = 1'b0, key_cancel = 1'b0, coin_valid = 1'b0;
  logic [3:0]    key_digit = '0;
  logic [CW-1:0] coin_value = '0;
  logic          sel_valid = 1'b0, dispense_ack = 1'b0;
  logic [3:0]    sel_dispense_row = '0, sel_dispense_col = '0;
  logic [PW-1:0] sel_price = '0;
  logic [3:0]    sel_row, sel_col, dispense_row, dispense_col;
  logic          sel_enter, dispense_req, change_valid, coin_reject, key_error, sold_out, busy;
  logic [PW-1:0] change_amount;

  always #5 clk = ~clk;

  vm_transaction_controller #(.PRICE_W(PW), .COIN_W(CW), .MAX_ROW(MR), .MAX_COL(MC),
                              .TIMEOUT_CYCLES(TO), .TIMER_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .key_valid(key_valid), .key_digit(key_digit), .key_cancel(key_cancel),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_row(sel_row), .sel_col(sel_col), .sel_enter(sel_enter),
    .sel_valid(sel_valid), .sel_dispense_row(sel_dispense_row),
    .sel_dispense_col(sel_dispense_col), .sel_price(sel_price),
    .dispense_req(dispense_req), .dispense_row(dispense_row), .dispense_col(dispense_col),
    .dispense_ack(dispense_ack), .change_valid(change_valid), .change_amount(change_amount),
    .coin_reject(coin_reject), .key_error(key_error), .sold_out(sold_out), .busy(busy)
  );

  int checks = 0, failures = 0;

  typedef enum int {EV_KERR, EV_SOLD, EV_REJ, EV_DISP, EV_CHG} ev_kind_e;
  typedef struct { ev_kind_e kind; int a; int b; } ev_t;
  ev_t exp_q[$];

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input int a, input int b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input int a, input int b);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got %s %0d/%0d expected none", k.name(), a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b) begin
        failures++;
        $display("FAIL event: got %s %0d/%0d expected %s %0d/%0d",
                 k.name(), a, b, e.kind.name(), e.a, e.b);
      end
    end
  endtask

  // Monitor
  logic prev_req = 1'b0;
  int   held_row = 0, held_col = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (key_error)   observe(EV_KERR, 0, 0);
      if (sold_out)    observe(EV_SOLD, 0, 0);
      if (coin_reject) observe(EV_REJ, 0, 0);
      if (dispense_req && !prev_req) begin
        observe(EV_DISP, int'(dispense_row), int'(dispense_col));
        held_row = int'(dispense_row);
        held_col = int'(dispense_col);
      end else if (dispense_req) begin
        check("dispense_pos_stable", int'({dispense_row, dispense_col}), held_row * 16 + held_col);
      end
      if (change_valid) observe(EV_CHG, int'(change_amount), 0);
      else check("change_amount_idle", int'(change_amount), 0);
      prev_req <= dispense_req;
    end else begin
      prev_req <= 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: each starts and ends aligned to a falling edge.
  task automatic key(input int d);
    key_valid = 1'b1; key_digit = 4'(d);
    @(negedge clk);
    key_valid = 1'b0; key_digit = '0;
  endtask

  task automatic coin(input int v, input bit with_cancel = 1'b0);
    coin_valid = 1'b1; coin_value = CW'(v); key_cancel = with_cancel;
    @(negedge clk);
    coin_valid = 1'b0; coin_value = '0; key_cancel = 1'b0;
  endtask

  task automatic cancel();
    key_cancel = 1'b1;
    @(negedge clk);
    key_cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic select(input int row, input int col, input bit ok, input bit echo_ok, input int price);
    int n = 0;
    while (!sel_enter && n < 10) begin @(negedge clk); n++; end
    check("sel_enter_seen", int'(sel_enter), 1);
    check("sel_row", int'(sel_row), row);
    check("sel_col", int'(sel_col), col);
    @(negedge clk);
    check("sel_row_hold", int'(sel_row), row);
    check("sel_enter_one_cycle", int'(sel_enter), 0);
    sel_valid        = ok;
    sel_dispense_row = 4'(echo_ok ? row : (row % MR) + 1);
    sel_dispense_col = 4'(col);
    sel_price        = PW'(price);
    @(negedge clk);
    sel_valid = 1'b0; sel_dispense_row = '0; sel_dispense_col = '0; sel_price = '0;
  endtask

  task automatic finish_dispense(input int delay);
    int n = 0;
    while (!dispense_req && n < 10) begin @(negedge clk); n++; end
    check("dispense_req_rise", int'(dispense_req), 1);
    idle(delay);
    dispense_ack = 1'b1;
    @(negedge clk);
    dispense_ack = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    check("busy_low", int'(busy), 0);
    idle(2);
    check("queue_drained", exp_q.size(), 0);
  endtask

  function automatic int pick_coin();
    int vals[6];
    vals = '{5, 10, 25, 50, 100, 200};
    return vals[$urandom_range(0, 5)];
  endfunction

  function automatic int bad_digit();
    int b;
    b = int'($urandom_range(0, 9));
    return (b == 0) ? 0 : 6 + b;
  endfunction

  task automatic rand_txn();
    int mode, row, col, price, credit, c, n;
    mode = int'($urandom_range(0, 6));
    row  = int'($urandom_range(1, MR));
    col  = int'($urandom_range(1, MC));
    case (mode)
      0, 1: begin
        price = int'($urandom_range(0, 600));
        key(row); key(col);
        expect_ev(EV_DISP, row, col);
        select(row, col, 1'b1, 1'b1, price);
        credit = 0;
        while (credit < price) begin
          c = pick_coin();
          idle(int'($urandom_range(0, 3)));
          coin(c);
          credit = sat(credit + c);
        end
        if (credit - price != 0) expect_ev(EV_CHG, credit - price, 0);
        finish_dispense(int'($urandom_range(0, 3)));
      end
      2, 3: begin
        price = int'($urandom_range(300, 900));
        key(row); key(col);
        select(row, col, 1'b1, 1'b1, price);
        credit = 0;
        n = int'($urandom_range(0, 3));
        for (int i = 0; i < n; i++) begin
          c = pick_coin();
          if (credit + c < price) begin
            idle(int'($urandom_range(0, 3)));
            coin(c);
            credit += c;
          end
        end
        idle(int'($urandom_range(0, 3)));
        if (mode == 3) begin
          if (credit != 0) expect_ev(EV_CHG, credit, 0);
          idle(TO + 4);
        end else if ($urandom_range(0, 1) == 1) begin
          c = pick_coin();
          expect_ev(EV_CHG, credit + c, 0);
          coin(c, 1'b1);
        end else begin
          if (credit != 0) expect_ev(EV_CHG, credit, 0);
          cancel();
        end
      end
      4: begin
        key(row); key(col);
        expect_ev(EV_SOLD, 0, 0);
        if ($urandom_range(0, 1) == 1) select(row, col, 1'b0, 1'b1, 100);
        else select(row, col, 1'b1, 1'b0, 100);
      end
      5: begin
        if ($urandom_range(0, 1) == 1) begin
          expect_ev(EV_KERR, 0, 0);
          key(bad_digit());
        end else begin
          key(row);
          expect_ev(EV_KERR, 0, 0);
          key(bad_digit());
        end
      end
      default: begin
        key(row);
        if ($urandom_range(0, 1) == 1) cancel();
        else idle(TO + 4);
        check("getcol_abandon_idle", int'(busy), 0);
        expect_ev(EV_REJ, 0, 0);
        coin(pick_coin());
      end
    endcase
    wait_idle();
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", int'({sel_row, sel_col, sel_enter, dispense_req, dispense_row, dispense_col}), 0);
    check("reset_outputs_b", int'({change_valid, change_amount, coin_reject, key_error, sold_out, busy}), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic purchase with change
    key(1); key(1);
    expect_ev(EV_DISP, 1, 1);
    select(1, 1, 1'b1, 1'b1, 250);
    coin(100); coin(100); coin(100);
    expect_ev(EV_CHG, 50, 0);
    finish_dispense(1);
    wait_idle();

    // Sold out, then a coin while idle is rejected
    key(1); key(2);
    expect_ev(EV_SOLD, 0, 0);
    select(1, 2, 1'b0, 1'b1, 0);
    wait_idle();
    expect_ev(EV_REJ, 0, 0);
    coin(25);
    wait_idle();

    // Out-of-range digits
    expect_ev(EV_KERR, 0, 0);
    key(7);
    idle(1);
    check("busy_after_bad_row", int'(busy), 0);
    key(3);
    expect_ev(EV_KERR, 0, 0);
    key(0);
    wait_idle();

    // Cancel with a same-cycle coin refunds everything
    key(2); key(4);
    select(2, 4, 1'b1, 1'b1, 650);
    coin(200); coin(100);
    expect_ev(EV_CHG, 350, 0);
    coin(50, 1'b1);
    wait_idle();

    // Timeout refund latency
    key(4); key(5);
    select(4, 5, 1'b1, 1'b1, 310);
    expect_ev(EV_CHG, 100, 0);
    coin_valid = 1'b1; coin_value = CW'(100);
    @(posedge clk);
    @(negedge clk);
    coin_valid = 1'b0; coin_value = '0;
    k = 0;
    while (k < 30) begin
      @(posedge clk); #1; k++;
      if (change_valid) break;
    end
    check("timeout_latency", k, TO);
    @(negedge clk);
    wait_idle();

    // Credit saturates at the top of the price range
    key(6); key(6);
    select(6, 6, 1'b1, 1'b1, CMAX);
    for (int i = 0; i < 16; i++) coin(255);
    expect_ev(EV_CHG, CMAX, 0);
    coin(255, 1'b1);
    wait_idle();

    // Reset during dispense clears outputs immediately
    key(2); key(3);
    expect_ev(EV_DISP, 2, 3);
    select(2, 3, 1'b1, 1'b1, 100);
    coin(100);
    k = 0;
    while (!dispense_req && k < 10) begin @(negedge clk); k++; end
    check("dispense_before_reset", int'(dispense_req), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset_outputs_a", int'({sel_row, sel_col, sel_enter, dispense_req, dispense_row, dispense_col}), 0);
    check("mid_reset_outputs_b", int'({change_valid, change_amount, coin_reject, key_error, sold_out, busy}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wait_idle();

    for (int t = 0; t < 60; t++) rand_txn();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
